// File: rtl/uart_pkg.sv
// Shared UART message definitions: ROM geometry, byte width and sequencer states.
package uart_pkg;

  localparam int RAM_ADDR_W = 9;
  localparam int RAM_DEPTH  = 512;
  localparam int BYTE_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
    FIN
  } msg_seq_state_t;

endpackage

// File: rtl/uart_msg_seq.sv
// Streams a window of the message ROM to the UART TX byte port over valid/ready.
// Build option UART_MSG_SEQ_NUL_STOP_EN ends a message early at the first 0x00 byte.
module uart_msg_seq
  import uart_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_len,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_ram_addr,
  input  logic [DATA_W-1:0] i_ram_data,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  msg_seq_state_t  state;
  logic [ADDR_W:0] remain;
  logic [ADDR_W:0] len_clamped;

  assign len_clamped = (i_len > MAX_LEN) ? MAX_LEN : i_len;

  // Outputs are assigned alongside the next state so they stay purely registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      remain     <= '0;
      o_ram_addr <= '0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            o_ram_addr <= i_base;
            remain     <= len_clamped;
            o_busy     <= 1'b1;
            if (len_clamped == '0) begin
              state  <= FIN;
              o_done <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (i_abort) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (i_abort) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
`ifdef UART_MSG_SEQ_NUL_STOP_EN
          else if (i_ram_data == '0) begin
            state  <= FIN;
            o_done <= 1'b1;
          end
`endif
          else begin
            o_tx_data  <= i_ram_data;
            o_tx_valid <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          // A byte accepted in the abort cycle is still counted as delivered.
          if (i_tx_ready) remain <= remain - ONE;
          if (i_abort) begin
            state      <= IDLE;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
          end else if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            if (remain == ONE) begin
              state  <= FIN;
              o_done <= 1'b1;
            end else begin
              o_ram_addr <= o_ram_addr + 1'b1;
              state      <= FETCH;
            end
          end
        end
        FIN: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          o_tx_valid <= 1'b0;
          o_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
